// File: rtl/en_reg_led.sv
// en_reg_led: enable-gated shift/load register with per-bit LED stretching.
//
// The register either loads d_i, shifts left or right with ser_i as the
// incoming bit, clears, or holds when en_i is low. Every bit drives an LED
// output. When a bit falls from 1 to 0, its LED stays lit for STRETCH more
// cycles, so short pulses remain visible. lamp_test_i lights every LED and
// does not change any stored state.
//
// Parameters
//   WIDTH       register width, 1..32
//   STRETCH     LED off-delay in cycles after a bit falls, 0..255 (0 = none)
// Ports
//   clk_i       clock, rising edge
//   rst_i       asynchronous active-high reset
//   en_i        enable; the register holds when low
//   mode_i      00 load, 01 shift-left, 10 shift-right, 11 clear
//   d_i         parallel load data
//   ser_i       serial input bit
//   lamp_test_i forces all LEDs on
//   q_o         register contents
//   ser_o       serial out: MSB while shifting left, LSB otherwise
//   led_o       per-bit LED drive, active-high
module en_reg_led #(
    parameter int WIDTH   = 8,
    parameter int STRETCH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [1:0]       mode_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             ser_i,
    input  logic             lamp_test_i,
    output logic [WIDTH-1:0] q_o,
    output logic             ser_o,
    output logic [WIDTH-1:0] led_o
);

    // Counter width must hold STRETCH itself. A single bit is still needed when STRETCH is 0.
    localparam int CW = (STRETCH > 0) ? $clog2(STRETCH + 1) : 1;
    localparam logic [CW-1:0] STRETCH_C = CW'(STRETCH);

    logic [WIDTH-1:0]         q_r;
    logic [WIDTH-1:0]         q_next_s;
    logic [WIDTH-1:0]         fall_s;
    logic [WIDTH-1:0]         rise_s;
    logic [WIDTH-1:0]         stretch_on_s;
    logic [WIDTH-1:0][CW-1:0] cnt_r;

    // Next register value from enable and mode.
    // The shift loops are written bitwise so that WIDTH=1 reduces to loading ser_i.
    always_comb begin
        q_next_s = q_r;
        if (en_i) begin
            case (mode_i)
                2'b00: q_next_s = d_i;
                2'b01: begin
                    q_next_s[0] = ser_i;
                    for (int i = 1; i < WIDTH; i++) begin
                        q_next_s[i] = q_r[i-1];
                    end
                end
                2'b10: begin
                    q_next_s[WIDTH-1] = ser_i;
                    for (int i = 0; i < WIDTH - 1; i++) begin
                        q_next_s[i] = q_r[i+1];
                    end
                end
                2'b11:   q_next_s = '0;
                default: q_next_s = q_r;
            endcase
        end else begin
            q_next_s = q_r;
        end
    end

    // Edge detection compares the current bits with the bits that the next clock edge will commit.
    always_comb begin
        fall_s = q_r & ~q_next_s;
        rise_s = ~q_r & q_next_s;
    end

    // Register contents and per-bit stretch counters.
    // The counters keep running while en_i is low.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_r   <= '0;
            cnt_r <= '0;
        end else begin
            q_r <= q_next_s;
            for (int k = 0; k < WIDTH; k++) begin
                if (fall_s[k]) begin
                    cnt_r[k] <= STRETCH_C;
                end else if (rise_s[k]) begin
                    cnt_r[k] <= '0;
                end else if (cnt_r[k] != '0) begin
                    cnt_r[k] <= cnt_r[k] - CW'(1);
                end else begin
                    cnt_r[k] <= cnt_r[k];
                end
            end
        end
    end

    // The LED drive is derived from registered state only. Lamp test overrides it.
    always_comb begin
        for (int k = 0; k < WIDTH; k++) begin
            stretch_on_s[k] = (cnt_r[k] != '0);
        end
    end

    // Output assignments. During reset q_r is zero, so ser_o is 0 and led_o follows lamp_test_i.
    always_comb begin
        q_o   = q_r;
        ser_o = (mode_i == 2'b01) ? q_r[WIDTH-1] : q_r[0];
        led_o = {WIDTH{lamp_test_i}} | q_r | stretch_on_s;
    end

endmodule
